// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit
// Purpose  : Iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO pair.
//            Optional macro MDU_EARLY_OUT_EN ends multiplies early once the
//            remaining multiplier bits are zero.
// Revision : 1.0 - initial release
// ============================================================================
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int c_CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_opb;
    logic                 r_is_div;
    logic                 r_sign_a;
    logic                 r_neg;
    logic                 r_dz_pend;

    logic                 w_accept;
    logic                 w_last;
    logic                 w_early;
    logic                 w_sa;
    logic                 w_sb;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_shifted;
    logic [WIDTH:0]       w_diff;
    logic [WIDTH-1:0]     w_new_rem;
    logic [2*WIDTH-1:0]   w_acc_step;
    logic [2*WIDTH-1:0]   w_fix_acc;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;
    logic [WIDTH-1:0]     w_res_hi;
    logic [WIDTH-1:0]     w_res_lo;

    assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last   = (r_cnt == c_CNT_W'(WIDTH - 1));
    assign w_sa     = op[0] & a[WIDTH-1];
    assign w_sb     = op[0] & b[WIDTH-1];
    assign w_abs_a  = w_sa ? -a : a;
    assign w_abs_b  = w_sb ? -b : b;

    // Multiply: {partial high, multiplier} shifts right; product bits fill from the top.
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    // Divide: restoring step; the low half holds dividend bits shifting out / quotient bits in.
    assign w_shifted  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff     = w_shifted - {1'b0, r_opb};
    assign w_new_rem  = w_diff[WIDTH] ? w_shifted[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_acc_step = r_is_div ? {w_new_rem, r_acc[WIDTH-2:0], ~w_diff[WIDTH]}
                                 : {w_sum, r_acc[WIDTH-1:1]};

`ifdef MDU_EARLY_OUT_EN
    logic [WIDTH-1:0] w_mask;
    assign w_mask    = {WIDTH{1'b1}} >> (32'(r_cnt) + 32'd1);
    assign w_early   = !r_is_div && (((r_acc[WIDTH-1:0] >> 1) & w_mask) == '0);
    // Skipped iterations would only shift; apply them all at once.
    assign w_fix_acc = r_acc >> ((WIDTH - 1) - 32'(r_cnt));
`else
    assign w_early   = 1'b0;
    assign w_fix_acc = r_acc;
`endif

    assign w_prod = r_neg ? -w_fix_acc : w_fix_acc;
    assign w_quo  = r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    // With a zero divisor the remainder ends as |a|, so sign restore yields the original a.
    assign w_rem  = r_sign_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    assign w_res_hi = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
    assign w_res_lo = r_is_div ? (r_dz_pend ? {WIDTH{1'b1}} : w_quo) : w_prod[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last || w_early) w_next = S_FIX;
            end
            S_FIX: begin
                busy   = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = w_accept ? S_RUN : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_opb     <= '0;
            r_is_div  <= 1'b0;
            r_sign_a  <= 1'b0;
            r_neg     <= 1'b0;
            r_dz_pend <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            div_zero  <= 1'b0;
        end else if (w_accept) begin
            r_cnt     <= '0;
            r_is_div  <= op[1];
            r_sign_a  <= w_sa;
            r_neg     <= w_sa ^ w_sb;
            r_dz_pend <= op[1] && (b == '0);
            r_opb     <= op[1] ? w_abs_b : w_abs_a;
            r_acc     <= {{WIDTH{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
        end else if (r_state == S_RUN) begin
            r_acc <= w_acc_step;
            if (w_next == S_RUN) r_cnt <= r_cnt + 1'b1;
        end else if (r_state == S_FIX) begin
            hi       <= w_res_hi;
            lo       <= w_res_lo;
            div_zero <= r_dz_pend;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_div_unit
// Purpose  : Directed self-checking bench for mul_div_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    int vectors = 0;
    int errors  = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one op, returns on the negedge of the done cycle (or after a 100-cycle bound).
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int busy_bad);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_bad = 0;
        while (!done && lat < 100) begin
            if (busy !== 1'b1) busy_bad++;
            @(negedge clk);
            lat++;
        end
        if (busy !== 1'b0) busy_bad++;
    endtask

    int lat;
    int bb;
    int cyc;
    logic seen;

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_dz", 32'(div_zero), 32'd0);
        reset = 1'b0;

        do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bb);
        chk("multu_lat", 32'(lat), 32'd34);
        chk("multu_busy_window", 32'(bb), 32'd0);
        chk("multu_hi", hi, 32'hFFFFFFFE);
        chk("multu_lo", lo, 32'h00000001);
        @(negedge clk);
        chk("multu_done_pulse", 32'(done), 32'd0);

        do_op(2'b01, 32'hFFFFFFFD, 32'd7, lat, bb);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFEB);

        do_op(2'b11, 32'hFFFFFFF9, 32'd2, lat, bb);
        chk("div_lat", 32'(lat), 32'd34);
        chk("div_lo", lo, 32'hFFFFFFFD);
        chk("div_hi", hi, 32'hFFFFFFFF);

        do_op(2'b10, 32'hFFFFFFF9, 32'd2, lat, bb);
        chk("divu_lo", lo, 32'h7FFFFFFC);
        chk("divu_hi", hi, 32'h00000001);

        do_op(2'b10, 32'h00001234, 32'd0, lat, bb);
        chk("dz_lat", 32'(lat), 32'd34);
        chk("dz_hi", hi, 32'h00001234);
        chk("dz_lo", lo, 32'hFFFFFFFF);
        chk("dz_flag", 32'(div_zero), 32'd1);

        do_op(2'b11, 32'h80000000, 32'hFFFFFFFF, lat, bb);
        chk("ovf_lo", lo, 32'h80000000);
        chk("ovf_hi", hi, 32'h00000000);
        chk("ovf_dz_clear", 32'(div_zero), 32'd0);

        // A start during RUN must be ignored.
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd5; b = 32'h80000003;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        repeat (9) begin @(negedge clk); cyc++; end
        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
        @(negedge clk);
        cyc++;
        start = 1'b0;
        while (!done && cyc < 100) begin @(negedge clk); cyc++; end
        chk("ign_lat", 32'(cyc), 32'd34);
        chk("ign_hi", hi, 32'h00000002);
        chk("ign_lo", lo, 32'h8000000F);

        // Back-to-back: restart in the DONE cycle.
        do_op(2'b00, 32'd3, 32'd4, lat, bb);
        chk("b2b_first_lo", lo, 32'd12);
        start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_done_drop", 32'(done), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        cyc = 1;
        while (!done && cyc < 100) begin @(negedge clk); cyc++; end
        chk("b2b_lat", 32'(cyc), 32'd34);
        chk("b2b_lo", lo, 32'd14);
        chk("b2b_hi", hi, 32'd2);

        // Reset in the middle of a divide.
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        repeat (14) begin @(negedge clk); cyc++; end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_hi", hi, 32'h0);
        chk("midrst_lo", lo, 32'h0);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("midrst_no_done", 32'(seen), 32'd0);

`ifdef MDU_EARLY_OUT_EN
        do_op(2'b00, 32'h0000ABCD, 32'd1, lat, bb);
        chk("early_lat", 32'(lat), 32'd3);
        chk("early_lo", lo, 32'h0000ABCD);
        chk("early_hi", hi, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
